uart_tx_arbiter: RTL and testbench

- Shares the single `uart_core` transmitter between N_REQ requesters using round-robin arbitration.
- A requester may be granted a bounded burst of bytes before the grant rotates.
- Drives the core's `tx_data` and `tx_req` and tracks `tx_busy` to sequence one frame at a time.
- Sits between the `uart_core` TX side and on-chip byte producers.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default timing, and the frame-config field layout shared with uart_core.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WBUSY = 2'd2,
    ARB_WDONE = 2'd3
  } arb_state_t;

  localparam int ARB_START_TO_DEF = 4;

  // Frame-config register fields, bit positions as decoded by uart_core
  localparam int CFG_DBITS_LSB = 0;
  localparam int CFG_DBITS_MSB = 1;
  localparam int CFG_PAR_EN    = 2;
  localparam int CFG_PAR_ODD   = 3;
  localparam int CFG_STOP2     = 4;
  localparam int CFG_W         = 5;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and core-side signals of the TX arbiter, bundled.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DW-1:0]     data;
  logic [N_REQ-1:0]        ack;
  logic [DW-1:0]           core_tx_data;
  logic                    core_tx_req;
  logic                    core_tx_busy;
  logic [idx_w(N_REQ)-1:0] grant_id;
  logic                    active;
  logic                    start_err;

  modport master (
    input  req, data, core_tx_busy,
    output ack, core_tx_data, core_tx_req, grant_id, active, start_err
  );

  modport slave (
    output req, data, core_tx_busy,
    input  ack, core_tx_data, core_tx_req, grant_id, active, start_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req strictly after last_ptr,
// wrapping modulo N, with last_ptr itself as the lowest-priority candidate.
module rr_picker
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] last_ptr,
  output logic [idx_w(N)-1:0] winner,
  output logic                valid
);
  localparam int IW = idx_w(N);

  logic [IW-1:0] cand [N];
  logic [N-1:0]  hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(last_ptr) + gi + 1) % N);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from lowest to highest priority so the nearest hit wins
  always_comb begin
    winner = last_ptr;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        winner = cand[k];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_core transmitter between N_REQ byte
// producers, with optional bounded bursts and a start-of-frame watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 1,
  parameter int START_TO  = ARB_START_TO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW      = idx_w(N_REQ);
  localparam int BW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) + 1 : 1;
  localparam int TW      = (START_TO > 1) ? $clog2(START_TO) + 1 : 1;
  localparam int TO_LAST = (START_TO > 2) ? START_TO - 2 : 0;

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] last_ptr_reg, last_ptr_next;
  logic [IW-1:0] grant_id_reg, grant_id_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [DW-1:0] tx_data_reg, tx_data_next;
  logic          ok_reg, ok_next;
  logic          start_err_reg, start_err_next;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [IW-1:0] sel_idx;
  logic          keep_burst;
  logic [DW-1:0] req_bytes [N_REQ];

  rr_picker #(.N(N_REQ)) u_picker (
    .req      (bus.req),
    .last_ptr (last_ptr_reg),
    .winner   (pick_idx),
    .valid    (pick_valid)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign req_bytes[gi] = bus.data[DW*gi +: DW];
      assign bus.ack[gi]   = (state_reg == ARB_ISSUE) && (grant_id_reg == IW'(gi));
    end
  endgenerate

  // A burst only continues after a frame that actually went out
  assign keep_burst = bus.req[last_ptr_reg] && ok_reg &&
                      (int'(burst_cnt_reg) < MAX_BURST - 1);

  always_comb begin
    state_next     = state_reg;
    last_ptr_next  = last_ptr_reg;
    grant_id_next  = grant_id_reg;
    burst_cnt_next = burst_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    tx_data_next   = tx_data_reg;
    ok_next        = ok_reg;
    start_err_next = 1'b0;
    sel_idx        = last_ptr_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid && !bus.core_tx_busy) begin
          if (keep_burst) begin
            burst_cnt_next = (burst_cnt_reg == '1) ? burst_cnt_reg : burst_cnt_reg + 1'b1;
          end else begin
            sel_idx        = pick_idx;
            burst_cnt_next = '0;
          end
          tx_data_next  = req_bytes[sel_idx];
          grant_id_next = sel_idx;
          last_ptr_next = sel_idx;
          state_next    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        to_cnt_next = '0;
        state_next  = ARB_WBUSY;
      end
      ARB_WBUSY: begin
        if (bus.core_tx_busy) begin
          state_next = ARB_WDONE;
        end else if (to_cnt_reg >= TW'(TO_LAST)) begin
          start_err_next = 1'b1;
          burst_cnt_next = '0;
          ok_next        = 1'b0;
          state_next     = ARB_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      ARB_WDONE: begin
        if (!bus.core_tx_busy) begin
          ok_next    = 1'b1;
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ARB_IDLE;
      last_ptr_reg  <= IW'(N_REQ - 1);
      grant_id_reg  <= '0;
      burst_cnt_reg <= '0;
      to_cnt_reg    <= '0;
      tx_data_reg   <= '0;
      ok_reg        <= 1'b0;
      start_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_ptr_reg  <= last_ptr_next;
      grant_id_reg  <= grant_id_next;
      burst_cnt_reg <= burst_cnt_next;
      to_cnt_reg    <= to_cnt_next;
      tx_data_reg   <= tx_data_next;
      ok_reg        <= ok_next;
      start_err_reg <= start_err_next;
    end
  end

  assign bus.core_tx_req  = (state_reg == ARB_ISSUE);
  assign bus.core_tx_data = tx_data_reg;
  assign bus.grant_id     = grant_id_reg;
  assign bus.active       = (state_reg != ARB_IDLE);
  assign bus.start_err    = start_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two instances (MAX_BURST 1 and 3),
// each with a small uart_core busy model; only the selected one runs.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int FRAME = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, core_en, sel;

  uart_tx_arbiter_if #(.N_REQ(N), .DW(DW)) ifa ();
  uart_tx_arbiter_if #(.N_REQ(N), .DW(DW)) ifb ();

  uart_tx_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(1), .START_TO(4)) dut_a (
    .clk (clk), .rst (rst_a), .bus (ifa)
  );
  uart_tx_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(3), .START_TO(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (ifb)
  );

  // uart_core stand-in: busy rises the cycle after tx_req and lasts FRAME cycles
  logic busy_q [2];
  int   cnt_q  [2];
  logic txr    [2];
  logic rstv   [2];
  assign txr[0]  = ifa.core_tx_req;
  assign txr[1]  = ifb.core_tx_req;
  assign rstv[0] = rst_a;
  assign rstv[1] = rst_b;
  assign ifa.core_tx_busy = busy_q[0];
  assign ifb.core_tx_busy = busy_q[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rstv[k] || !core_en) begin
        busy_q[k] <= 1'b0;
        cnt_q[k]  <= 0;
      end else if (!busy_q[k] && txr[k]) begin
        busy_q[k] <= 1'b1;
        cnt_q[k]  <= FRAME - 1;
      end else if (busy_q[k]) begin
        if (cnt_q[k] == 0) busy_q[k] <= 1'b0;
        else cnt_q[k] <= cnt_q[k] - 1;
      end
    end
  end

  logic [N-1:0]  c_ack;
  logic          c_req, c_err, c_act, c_busy;
  logic [DW-1:0] c_data;
  logic [1:0]    c_gid;
  int            c_cnt;
  always_comb begin
    c_ack  = sel ? ifb.ack          : ifa.ack;
    c_req  = sel ? ifb.core_tx_req  : ifa.core_tx_req;
    c_err  = sel ? ifb.start_err    : ifa.start_err;
    c_act  = sel ? ifb.active       : ifa.active;
    c_busy = sel ? busy_q[1]        : busy_q[0];
    c_data = sel ? ifb.core_tx_data : ifa.core_tx_data;
    c_gid  = sel ? ifb.grant_id     : ifa.grant_id;
    c_cnt  = sel ? cnt_q[1]         : cnt_q[0];
  end

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;
  exp_t sbq [$];

  int left [N];
  int seq [N];
  int exp_seq [N];
  logic [N-1:0] ack_seen;
  int n_acks, n_checks, n_pass;

  function automatic logic [7:0] mkbyte(input int i, input int s);
    return 8'(32'h4A + 16 * i + s);
  endfunction

  function automatic bit any_left();
    for (int i = 0; i < N; i++) if (left[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ifa.req[i]            = (left[i] > 0);
      ifb.req[i]            = (left[i] > 0);
      ifa.data[DW*i +: DW]  = mkbyte(i, seq[i]);
      ifb.data[DW*i +: DW]  = mkbyte(i, seq[i]);
    end
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id = id;
    e.d  = mkbyte(id, exp_seq[id]);
    sbq.push_back(e);
    exp_seq[id]++;
  endtask

  task automatic monitor();
    exp_t e;
    ack_seen = c_ack;
    if (c_ack != '0) n_acks++;
    if (c_req) begin
      $display("issue dut=%0d grant=%0d data=%02h ack=%b", sel, c_gid, c_data, c_ack);
      check("sb_pending", 32'(sbq.size() > 0), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sb_grant_id", 32'(c_gid), 32'(e.id));
        check("sb_tx_data", 32'(c_data), 32'(e.d));
        check("sb_ack", 32'(c_ack), 32'(1 << e.id));
      end
    end else if (c_ack != '0) begin
      check("ack_outside_issue", 32'(c_ack), 32'd0);
    end
  endtask

  // One clock: sample at negedge, then let producers react to acks after the edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i] && left[i] > 0) begin
        left[i]--;
        seq[i]++;
      end
    end
    ack_seen = '0;
    drive();
  endtask

  task automatic do_reset(input logic which);
    sel   = which;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < N; i++) begin
      left[i]    = 0;
      seq[i]     = 0;
      exp_seq[i] = 0;
    end
    sbq.delete();
    ack_seen = '0;
    n_acks   = 0;
    drive();
    tick();
    tick();
    if (which) rst_b = 1'b0;
    else rst_a = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sbq.size() != 0 || c_act || any_left()) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_in_time"}, 32'(n < 300), 32'd1);
    check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    core_en  = 1'b1;

    // Reset state and single requester
    do_reset(1'b0);
    check("rst_ack", 32'(c_ack), 32'd0);
    check("rst_tx_req", 32'(c_req), 32'd0);
    check("rst_start_err", 32'(c_err), 32'd0);
    check("rst_tx_data", 32'(c_data), 32'd0);
    check("rst_grant_id", 32'(c_gid), 32'd0);
    check("rst_active", 32'(c_act), 32'd0);
    left[1] = 1;
    push_exp(1);
    drive();
    tick();
    check("single_tx_req", 32'(c_req), 32'd1);
    check("single_tx_data", 32'(c_data), 32'h5A);
    check("single_ack", 32'(c_ack), 32'b0010);
    check("single_grant", 32'(c_gid), 32'd1);
    n = 0;
    while (!c_busy && n < 10) begin tick(); n++; end
    check("single_busy_rose", 32'(n < 10), 32'd1);
    n = 0;
    while (c_busy && n < 20) begin tick(); n++; end
    check("single_busy_fell", 32'(n < 20), 32'd1);
    check("single_active_hold", 32'(c_act), 32'd1);
    tick();
    check("single_active_drop", 32'(c_act), 32'd0);
    wait_drain("single");

    // Full contention, pure round-robin
    do_reset(1'b0);
    left[0] = 2; left[1] = 2; left[2] = 1; left[3] = 1;
    push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0); push_exp(1);
    drive();
    wait_drain("rr");
    check("rr_ack_count", 32'(n_acks), 32'd6);

    // Start timeout: core never goes busy
    do_reset(1'b0);
    core_en = 1'b0;
    left[0] = 1; left[1] = 1;
    push_exp(0); push_exp(1);
    drive();
    n = 0;
    while (!c_req && n < 20) begin tick(); n++; end
    check("to_issue_seen", 32'(n < 20), 32'd1);
    n = 0;
    while (!c_err && n < 20) begin tick(); n++; end
    check("to_err_delay", 32'(n), 32'd4);
    check("to_back_idle", 32'(c_act), 32'd0);
    check("to_single_ack", 32'(n_acks), 32'd1);
    tick();
    check("to_err_pulse", 32'(c_err), 32'd0);
    wait_drain("to");
    core_en = 1'b1;

    // Reset in the middle of a frame
    do_reset(1'b0);
    left[2] = 1;
    push_exp(2);
    drive();
    n = 0;
    while (!(c_busy && c_act) && n < 30) begin tick(); n++; end
    check("mf_reach_busy", 32'(n < 30), 32'd1);
    tick();
    check("mf_grant", 32'(c_gid), 32'd2);
    check("mf_in_frame", 32'(c_act), 32'd1);
    rst_a = 1'b1;
    tick();
    check("mf_ack", 32'(c_ack), 32'd0);
    check("mf_tx_req", 32'(c_req), 32'd0);
    check("mf_start_err", 32'(c_err), 32'd0);
    check("mf_tx_data", 32'(c_data), 32'd0);
    check("mf_grant_rst", 32'(c_gid), 32'd0);
    check("mf_active", 32'(c_act), 32'd0);
    rst_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 1;
      push_exp(i);
    end
    drive();
    wait_drain("mf");

    // req3 rises in the cycle busy falls
    do_reset(1'b0);
    left[0] = 1;
    push_exp(0);
    drive();
    n = 0;
    while (!(c_busy && c_cnt == 0) && n < 40) begin tick(); n++; end
    check("b2b_last_busy", 32'(n < 40), 32'd1);
    tick();
    check("b2b_busy_fell", 32'(c_busy), 32'd0);
    left[3] = 1;
    push_exp(3);
    drive();
    check("b2b_no_req_fall", 32'(c_req), 32'd0);
    tick();
    check("b2b_no_req_idle", 32'(c_req), 32'd0);
    tick();
    check("b2b_tx_req", 32'(c_req), 32'd1);
    check("b2b_grant", 32'(c_gid), 32'd3);
    wait_drain("b2b");

    // Bursts of up to three bytes
    do_reset(1'b1);
    left[0] = 4; left[2] = 3;
    push_exp(0); push_exp(0); push_exp(0);
    push_exp(2); push_exp(2); push_exp(2);
    push_exp(0);
    drive();
    wait_drain("burst");
    check("burst_ack_count", 32'(n_acks), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
